aes_inv_subshift: RTL and testbench
===================================

Name: aes_inv_subshift

Overview:
Iterative InvShiftRows + InvSubBytes stage for the AES-256 decryption datapath. It consumes a 128-bit state and drives LANES parallel inverse S-box lookups per beat, so one state is processed in 16/LANES beats. It sits between the AddRoundKey/InvMixColumns logic of the previous round and the AddRoundKey of the current round. It has valid/ready handshakes on both sides.

Parameters:
LANES, 4, number of inverse S-box instances per beat. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
BEATS, 16/LANES, derived value, not overridable: beats per block.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
in_valid  in  1  input state valid.
in_ready  out  1  stage can accept a state.
in_state  in  128  input state. Byte i = in_state[127-8i -: 8]; column-major, so byte i holds row i%4, column i/4.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_state  out  128  result state, same byte order as in_state.

Behaviour:
- Function: output byte j = INV_SBOX(input byte src(j)), where j = 4c+r and src(j) = 4*((c-r) mod 4) + r. This is InvShiftRows (row r rotated right by r) followed by InvSubBytes; the two operations commute.
- FSM states:
  - IDLE: in_ready = 1, out_valid = 0.
  - BUSY: in_ready = 0, out_valid = 0. Beat counter k runs 0..BEATS-1.
  - DONE: out_valid = 1, in_ready = out_ready.
- IDLE, in_valid=1 at edge E0: capture in_state into the source register, clear k to 0, go to BUSY.
- BUSY, edge per beat k: write result bytes j = k*LANES .. k*LANES+LANES-1, each from the INV_SBOX of source byte src(j). Then k increments. At k = BEATS-1 go to DONE instead of incrementing.
- Latency: out_valid rises after edge E0+BEATS (LANES=4: 4 cycles). Result bytes not yet written are don't-care while in BUSY.
- DONE, out_ready=1, in_valid=0: transfer completes; go to IDLE.
- DONE, out_ready=1, in_valid=1: transfer completes and the new state is captured on the same edge; go to BUSY with k=0. Throughput is one block per BEATS+1 cycles.
- DONE, out_ready=0: hold; out_state and out_valid are stable and in_ready = 0. in_state is ignored.
- in_valid while in BUSY is ignored. The upstream stage must hold its data because in_ready=0.
- Reset, asynchronous at any time including mid-block:
  - FSM goes to IDLE, k = 0.
  - Source and result registers are cleared to 0, so out_state = 0 and out_valid = 0.
  - in_ready = 1 from the first cycle after rst deasserts.
  - A partially processed block is discarded with no output.
- out_state is driven directly from the result register; there is no combinational path from in_state to out_state.
- All outputs are registered except in_ready, which is combinational from the FSM state and out_ready.

Decomposition:
- Shared package aes_pkg holds:
  - the 128-bit state typedef and 8-bit byte typedef;
  - a function byte_of(state, i) for the byte index convention;
  - the constant 16-entry INV_SHIFT_SRC table giving src(j);
  - the FSM state enum {IDLE, BUSY, DONE}.
- The one sub-module is the existing combinational inverse S-box lookup (inv_sbox), instantiated LANES times in a generate loop. This block adds no new lookup logic.

Test Plan:
- Zero vector, LANES=4: in_state = 0 -> after exactly 4 cycles out_valid=1 and out_state = 128'h52525252_52525252_52525252_52525252.
- Ramp, LANES=4: in_state = 128'h00010203_04050607_08090a0b_0c0d0e0f -> out_state = 128'h52f3a338_3009d79e_bf366afb_8140a5d5.
- Identity check: in_state = all bytes 8'h63 -> out_state = 0. Repeat with LANES=1 (16-cycle latency) and LANES=16 (1-cycle latency); results must be identical across all three.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_state stable, in_ready=0, and a pulsed in_valid is not accepted. Raise out_ready with in_valid=1 -> the next block is captured on the same edge and its result appears 4 cycles later.
- Back-to-back stream of 8 random states with out_ready=1 -> every result matches the reference model, with one block completed every 5 cycles.
- Reset mid-block: assert rst during beat 2 -> out_valid=0, out_state=0 and in_ready=1 immediately. No output for the aborted block; the next accepted block completes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES decryption types, byte-order helper, InvShiftRows source map and stage FSM encoding.
package aes_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  // src(j) for output byte j = 4c+r: row r rotated right by r, so it reads column (c-r) mod 4.
  localparam logic [3:0] INV_SHIFT_SRC [16] = '{
    4'd0,  4'd13, 4'd10, 4'd7,
    4'd4,  4'd1,  4'd14, 4'd11,
    4'd8,  4'd5,  4'd2,  4'd15,
    4'd12, 4'd9,  4'd6,  4'd3
  };

  // Byte 0 sits in the most significant position of the state word.
  function automatic aes_byte_t byte_of(input aes_state_t s, input logic [3:0] i);
    return s[127 - 8*int'(i) -: 8];
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [7:0] INV_SBOX_TAB [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign y = INV_SBOX_TAB[a];

endmodule

// File: rtl/aes_inv_subshift.sv
// Iterative InvShiftRows+InvSubBytes, LANES bytes per beat; result valid BEATS cycles after capture.
// Holds the result under out_ready=0 and refuses new input until it is taken.
module aes_inv_subshift
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int BEATS = 16 / LANES;
  localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_inv_subshift: LANES must be 1, 2, 4, 8 or 16");
  end

  fsm_t          state_q, state_d;
  logic [KW-1:0] k_q;
  aes_state_t    src_q, res_q;
  logic          accept;
  logic [3:0]    lane_j [LANES];
  aes_byte_t     lane_y [LANES];

  // Lane l of beat k produces output byte k*LANES+l.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_j[l] = 4'(int'(k_q) * LANES + l);
    inv_sbox u_inv_sbox (
      .a (byte_of(src_q, INV_SHIFT_SRC[lane_j[l]])),
      .y (lane_y[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (k_q == K_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q     <= '0;
      res_q     <= '0;
      k_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_d == DONE);
      if (accept) begin
        src_q <= in_state;
        k_q   <= '0;
      end else if (state_q == BUSY) begin
        for (int l = 0; l < LANES; l++) begin
          res_q[127 - 8*int'(lane_j[l]) -: 8] <= lane_y[l];
        end
        if (k_q != K_LAST) k_q <= k_q + 1'b1;
      end
    end
  end

  assign out_state = res_q;

endmodule

// File: tb/tb_aes_inv_subshift.sv
// Scoreboarded bench: LANES=4 main instance plus LANES=1 and LANES=16 instances for cross-width checks.
module tb_aes_inv_subshift;

  typedef struct {
    logic [127:0] d;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv   [3];
  logic         ir   [3];
  logic [127:0] ist  [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] ost  [3];

  exp_t q0[$], q1[$], q2[$];
  logic [7:0] isb [256];
  bit   lat_done [3];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_inv_subshift #(.LANES((g == 0) ? 4 : ((g == 1) ? 1 : 16))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_state  (ist[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_state (ost[g])
    );
  end

  function automatic int beats_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 16 : 1);
  endfunction

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  // Forward S-box from field inverse + affine map, then inverted into isb.
  task automatic build_isb();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b;
      logic [7:0] s;
      b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      isb[s] = 8'(x);
    end
  endtask

  // InvShiftRows moves (r,c) to (r,(c+r) mod 4); InvSubBytes applied per byte.
  function automatic logic [127:0] ref_model(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8*(4*((c + r) % 4) + r) -: 8] = isb[s[127 - 8*(4*c + r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int i);
    exp_t e;
    int   sz;
    case (i)
      0:       sz = q0.size();
      1:       sz = q1.size();
      default: sz = q2.size();
    endcase
    if (!ov[i]) return;
    if (sz == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_output inst %0d: got %h expected no output", i, ost[i]);
      return;
    end
    case (i)
      0:       e = q0[0];
      1:       e = q1[0];
      default: e = q2[0];
    endcase
    if (!lat_done[i]) begin
      check($sformatf("latency_inst%0d", i), 128'(cyc), 128'(e.cyc));
      lat_done[i] = 1'b1;
    end
    if (ordy[i]) begin
      check($sformatf("data_inst%0d", i), ost[i], e.d);
      case (i)
        0:       void'(q0.pop_front());
        1:       void'(q1.pop_front());
        default: void'(q2.pop_front());
      endcase
      lat_done[i] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) mon(i);
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input int i, input logic [127:0] d, input logic [127:0] e, output int acc);
    exp_t x;
    bit   ok;
    ok = 1'b0;
    acc = -1;
    iv[i] = 1'b1;
    ist[i] = d;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (ir[i]) begin
        x.d = e;
        x.cyc = cyc + 1 + beats_of(i);
        push_exp(i, x);
        acc = cyc + 1;
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    iv[i] = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout inst %0d: got no in_ready expected acceptance", i);
    end
  endtask

  task automatic drain(input int i);
    int sz;
    sz = 1;
    for (int t = 0; t < 200 && sz != 0; t++) begin
      @(posedge clk);
      #1;
      case (i)
        0:       sz = q0.size();
        1:       sz = q1.size();
        default: sz = q2.size();
      endcase
    end
    if (sz != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout inst %0d: got %0d pending expected 0", i, sz);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] a, b, c, id63;
    int acc, prev;
    bit seen;

    build_isb();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ist[i] = '0;
      ordy[i] = 1'b1;
      lat_done[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_out_valid_inst%0d", i), 128'(ov[i]), 128'(0));
      check($sformatf("rst_out_state_inst%0d", i), ost[i], 128'h0);
      check($sformatf("rst_in_ready_inst%0d", i), 128'(ir[i]), 128'(1));
    end
    @(posedge clk);
    #1;

    send(0, 128'h0, {16{8'h52}}, acc);
    drain(0);
    send(0, 128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h52f3a338_3009d79e_bf366afb_8140a5d5, acc);
    drain(0);

    id63 = {16{8'h63}};
    for (int i = 0; i < 3; i++) begin
      send(i, id63, 128'h0, acc);
      drain(i);
      a = rnd128();
      send(i, a, ref_model(a), acc);
      drain(i);
    end

    // Backpressure: result must hold and a stray in_valid must be refused.
    ordy[0] = 1'b0;
    a = rnd128();
    b = rnd128();
    c = rnd128();
    send(0, a, ref_model(a), acc);
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = ov[0];
    end
    check("bp_valid_seen", 128'(seen), 128'(1));
    for (int t = 0; t < 10; t++) begin
      @(posedge clk);
      #1;
      iv[0] = (t == 4);
      ist[0] = b;
      @(negedge clk);
      check("bp_hold_state", ost[0], ref_model(a));
      check("bp_in_ready", 128'(ir[0]), 128'(0));
    end
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    send(0, c, ref_model(c), acc);
    drain(0);

    // Back-to-back stream: one block every BEATS+1 cycles.
    prev = -1;
    for (int n = 0; n < 8; n++) begin
      a = rnd128();
      send(0, a, ref_model(a), acc);
      if (prev >= 0) check("stream_spacing", 128'(acc - prev), 128'(5));
      prev = acc;
    end
    drain(0);

    // Reset during beat 2 discards the block.
    a = rnd128();
    send(0, a, ref_model(a), acc);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(ov[0]), 128'(0));
    check("midrst_out_state", ost[0], 128'h0);
    check("midrst_in_ready", 128'(ir[0]), 128'(1));
    q0.delete();
    lat_done[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_output", 128'(ov[0]), 128'(0));
    end
    @(posedge clk);
    #1;
    b = rnd128();
    send(0, b, ref_model(b), acc);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
